regfile_write_arbiter: RTL

//  Sequences and shares the single write port of the 32x32 register file.

---
 rtl/regfile_write_arbiter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter
//
// Owns the single write port of the 32x32 register file. It has two jobs:
//   * Clear sweep: after reset, or when Clr is pulsed, it writes zero to
//     registers 0..NREGS-1, one register per cycle.
//   * Arbitration: in normal operation it round-robin arbitrates NREQ
//     writeback requesters onto EnW/WAdd/DIn. The write port is driven
//     from one registered output stage.
//
// Parameters
//   NREQ        number of writeback requesters (2..8)
//   NREGS       number of registers the clear sweep covers (<= 32)
//   DISCARD_R0  1: a granted write to address 0 is consumed with EnW=0
//
// Ports
//   Clk      in   1        clock; all state changes on the rising edge
//   Reset    in   1        asynchronous, active-low reset
//   Clr      in   1        pulse that starts a clear sweep (sampled in ARB only)
//   Req      in   NREQ     Req[i]=1: requester i has a write pending
//   ReqAdd   in   NREQ*5   requester i address in bits [5i+4:5i]
//   ReqData  in   NREQ*32  requester i data in bits [32i+31:32i]
//   Gnt      out  NREQ     one-hot (or zero) accept, combinational
//   EnW      out  1        registered write enable
//   WAdd     out  5        registered write address
//   DIn      out  32       registered write data
//   Busy     out  1        high while a clear sweep is in progress
// ---------------------------------------------------------------------------
module regfile_write_arbiter #(
  parameter int NREQ       = 3,
  parameter int NREGS      = 32,
  parameter int DISCARD_R0 = 1
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Clr,
  input  logic [NREQ-1:0]      Req,
  input  logic [NREQ*5-1:0]    ReqAdd,
  input  logic [NREQ*32-1:0]   ReqData,
  output logic [NREQ-1:0]      Gnt,
  output logic                 EnW,
  output logic [4:0]           WAdd,
  output logic [31:0]          DIn,
  output logic                 Busy
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_ARB   = 1'b1
  } state_t;

  // Control state
  state_t              r_state;
  logic [4:0]          r_cnt;
  logic [PTR_W-1:0]    r_ptr;

  // Registered write-port stage
  logic                r_vld_p1;
  logic [4:0]          r_wadd_p1;
  logic [31:0]         r_din_p1;

  // Requester fields unpacked for indexing by the winner
  logic [4:0]          w_add_arr  [NREQ];
  logic [31:0]         w_data_arr [NREQ];

  // Arbitration result
  logic                w_found;
  logic [PTR_W-1:0]    w_win;
  logic [PTR_W-1:0]    w_idx;
  logic [4:0]          w_win_add;
  logic [31:0]         w_win_data;
  logic                w_arb_go;
  logic                w_drop_r0;

  // Next round-robin position. The wrap is explicit so that a NREQ that is
  // not a power of two never lets the pointer reach an unused code.
  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(NREQ - 1)) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      w_add_arr[i]  = ReqAdd[5*i +: 5];
      w_data_arr[i] = ReqData[32*i +: 32];
    end
  end

  // Priority search starting at r_ptr and walking forward with wrap-around.
  // The first requester found from the pointer position wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = r_ptr;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && Req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
      w_idx = wrap_inc(w_idx);
    end
  end

  assign w_win_add  = w_add_arr[w_win];
  assign w_win_data = w_data_arr[w_win];

  // A grant is only offered in ARB and never in the cycle Clr is seen:
  // Clr takes priority, so no transfer may complete on that edge.
  assign w_arb_go  = (r_state == S_ARB) && !Clr && w_found;
  assign w_drop_r0 = (DISCARD_R0 != 0) && (w_win_add == 5'd0);

  always_comb begin
    Gnt = '0;
    if (w_arb_go) begin
      Gnt = NREQ'(1) << w_win;
    end
  end

  // ---- stage p0 -> p1 : control state and registered write port ----
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state   <= S_CLEAR;
      r_cnt     <= '0;
      r_ptr     <= '0;
      r_vld_p1  <= 1'b0;
      r_wadd_p1 <= '0;
      r_din_p1  <= '0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          // Zero one register per edge; Clr is ignored so the sweep
          // always completes from wherever it started.
          r_vld_p1  <= 1'b1;
          r_wadd_p1 <= r_cnt;
          r_din_p1  <= '0;
          if (r_cnt == 5'(NREGS - 1)) begin
            r_cnt   <= '0;
            r_state <= S_ARB;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
          end
        end
        S_ARB: begin
          if (Clr) begin
            r_state  <= S_CLEAR;
            r_cnt    <= '0;
            r_vld_p1 <= 1'b0;
          end else if (w_found) begin
            // A write to r0 is still a completed transfer (the requester
            // sees its grant and the pointer moves on); only the enable
            // is suppressed.
            r_vld_p1  <= !w_drop_r0;
            r_wadd_p1 <= w_win_add;
            r_din_p1  <= w_win_data;
            r_ptr     <= wrap_inc(w_win);
          end else begin
            r_vld_p1  <= 1'b0;
          end
        end
        default: begin
          r_state  <= S_CLEAR;
          r_cnt    <= '0;
          r_vld_p1 <= 1'b0;
        end
      endcase
    end
  end

  assign EnW  = r_vld_p1;
  assign WAdd = r_wadd_p1;
  assign DIn  = r_din_p1;
  assign Busy = (r_state == S_CLEAR);

endmodule
